// File: rtl/cordic_vec_mag.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vec_mag
// Description : Iterative CORDIC vectoring engine. It removes a common offset
//               from two raw converter codes, then returns the gain-compensated
//               magnitude sqrt(dx^2+dy^2) and the full-circle phase
//               atan2(dy,dx). Control is a START/BUSY/DONE handshake, and the
//               results are held until the next operation completes.
// Ports       : clk_i      - rising-edge clock
//               rst_i      - synchronous active-high reset
//               start_i    - start request, sampled only while idle
//               x_in_i     - unsigned raw X code (WIDTH)
//               y_in_i     - unsigned raw Y code (WIDTH)
//               offset_i   - unsigned offset subtracted from both channels
//               mag_o      - unsigned magnitude (WIDTH+1), registered
//               angle_o    - phase, 65536 = full turn, 0 = +X, CCW positive
//               busy_o     - operation in progress
//               done_o     - one-cycle pulse when mag_o/angle_o update
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vec_mag #(
    parameter int WIDTH     = 13,
    parameter int OFS_WIDTH = 10,
    parameter int ITER      = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     x_in_i,
    input  logic [WIDTH-1:0]     y_in_i,
    input  logic [OFS_WIDTH-1:0] offset_i,
    output logic [WIDTH:0]       mag_o,
    output logic [15:0]          angle_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // Fractional guard bits below the integer LSB. Without them a residual
    // y of -1 never changes sign once x>>>i reaches zero (arithmetic shift
    // floors towards -inf), and the angle accumulator keeps drifting on
    // small vectors.
    localparam int GUARD     = 8;
    localparam int XW        = WIDTH + 3 + GUARD;
    localparam int PW        = XW + 16;
    localparam int MAG_SHIFT = 16 + GUARD;

    localparam logic [PW-1:0] C_INV_GAIN  = PW'(39797);   // round(2^16/1.64676)
    localparam logic [PW-1:0] C_ROUND     = PW'(1) << (MAG_SHIFT - 1);
    localparam logic [3:0]    C_LAST      = 4'(ITER - 1);
    localparam logic [15:0]   C_HALF_TURN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_ROT   = 2'd2,
        ST_SCALE = 2'd3
    } state_t;

    state_t                state_q;
    logic [WIDTH-1:0]      xr_q;
    logic [WIDTH-1:0]      yr_q;
    logic [OFS_WIDTH-1:0]  ofs_q;
    logic signed [XW-1:0]  x_q;
    logic signed [XW-1:0]  y_q;
    logic [15:0]           z_q;
    logic                  zflag_q;
    logic [3:0]            cnt_q;
    logic [WIDTH:0]        mag_q;
    logic [15:0]           angle_q;
    logic                  busy_q;
    logic                  done_q;

    logic signed [WIDTH:0] dx_d;
    logic signed [WIDTH:0] dy_d;
    logic signed [XW-1:0]  dxe_d;
    logic signed [XW-1:0]  dye_d;
    logic signed [XW-1:0]  x_pre_d;
    logic signed [XW-1:0]  y_pre_d;
    logic [15:0]           z_pre_d;
    logic                  zflag_d;
    logic signed [XW-1:0]  x_sh_d;
    logic signed [XW-1:0]  y_sh_d;
    logic signed [XW-1:0]  x_rot_d;
    logic signed [XW-1:0]  y_rot_d;
    logic [15:0]           z_rot_d;
    logic [15:0]           at_d;
    logic [PW-1:0]         prod_d;
    logic [WIDTH:0]        mag_d;

    // Elementary angles atan(2^-i) in 2^16-per-turn units.
    function automatic logic [15:0] at_lut(input logic [3:0] idx);
        logic [15:0] v;
        case (idx)
            4'd0:    v = 16'd8192;
            4'd1:    v = 16'd4836;
            4'd2:    v = 16'd2555;
            4'd3:    v = 16'd1297;
            4'd4:    v = 16'd651;
            4'd5:    v = 16'd326;
            4'd6:    v = 16'd163;
            4'd7:    v = 16'd81;
            4'd8:    v = 16'd41;
            4'd9:    v = 16'd20;
            4'd10:   v = 16'd10;
            4'd11:   v = 16'd5;
            4'd12:   v = 16'd3;
            4'd13:   v = 16'd1;
            4'd14:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        // Offset removal; both operands are non-negative so one extra bit
        // is enough to hold the signed difference.
        dx_d    = $signed({1'b0, xr_q}) - $signed({1'b0, WIDTH'(ofs_q)});
        dy_d    = $signed({1'b0, yr_q}) - $signed({1'b0, WIDTH'(ofs_q)});
        zflag_d = (dx_d == '0) && (dy_d == '0);
        dxe_d   = XW'(dx_d) <<< GUARD;
        dye_d   = XW'(dy_d) <<< GUARD;

        // Fold the left half-plane onto the right by a 180 degree rotation so
        // the micro-rotations only ever need to cover +-90 degrees.
        if (dx_d[WIDTH]) begin
            x_pre_d = -dxe_d;
            y_pre_d = -dye_d;
            z_pre_d = C_HALF_TURN;
        end else begin
            x_pre_d = dxe_d;
            y_pre_d = dye_d;
            z_pre_d = 16'd0;
        end

        x_sh_d = x_q >>> cnt_q;
        y_sh_d = y_q >>> cnt_q;
        at_d   = at_lut(cnt_q);
        if (!y_q[XW-1]) begin
            x_rot_d = x_q + y_sh_d;
            y_rot_d = y_q - x_sh_d;
            z_rot_d = z_q + at_d;
        end else begin
            x_rot_d = x_q - y_sh_d;
            y_rot_d = y_q + x_sh_d;
            z_rot_d = z_q - at_d;
        end

        // x is never negative after the fold, so it is scaled as unsigned.
        prod_d = PW'($unsigned(x_q)) * C_INV_GAIN + C_ROUND;
        mag_d  = (WIDTH + 1)'(prod_d >> MAG_SHIFT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            ofs_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zflag_q <= 1'b0;
            cnt_q   <= '0;
            mag_q   <= '0;
            angle_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        xr_q    <= x_in_i;
                        yr_q    <= y_in_i;
                        ofs_q   <= offset_i;
                        busy_q  <= 1'b1;
                        state_q <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    x_q     <= x_pre_d;
                    y_q     <= y_pre_d;
                    z_q     <= z_pre_d;
                    zflag_q <= zflag_d;
                    cnt_q   <= '0;
                    state_q <= ST_ROT;
                end
                ST_ROT: begin
                    x_q   <= x_rot_d;
                    y_q   <= y_rot_d;
                    z_q   <= z_rot_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == C_LAST) begin
                        state_q <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    mag_q   <= mag_d;
                    // A zero vector has no defined phase; report 0.
                    angle_q <= zflag_q ? 16'd0 : z_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mag_o   = mag_q;
    assign angle_o = angle_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire
